// File: rtl/uart_mem_bridge_if.sv
// UART receive/transmit strobes and the synchronous memory port of the bridge.
// rx_done_tick and tx_done_tick are one-cycle strobes. tx_start is a one-cycle request, and tx_in holds until tx_done_tick.
// mem_we is a one-cycle write strobe. mem_rdata answers the mem_addr of the previous cycle.
interface uart_mem_bridge_if #(
  parameter int ADDR_W = 16
);
  logic              rx_done_tick;
  logic [7:0]        rx_out;
  logic              tx_start;
  logic [7:0]        tx_in;
  logic              tx_done_tick;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport master (
    input  rx_done_tick, rx_out, tx_done_tick, mem_rdata,
    output tx_start, tx_in, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output rx_done_tick, rx_out, tx_done_tick, mem_rdata,
    input  tx_start, tx_in, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Command-driven bridge: 'L' loads N received bytes into memory, then ACKs.
// 'S' streams memory addresses 0..N-1 back out over the UART, one byte at a time.
module uart_mem_bridge #(
  parameter int         ADDR_W   = 16,
  parameter logic [7:0] ACK_BYTE = 8'h41
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_mem_bridge_if.master        bus,
  output logic                     busy,
  output logic                     done_tick,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    LOAD    = 3'd3,
    ACK     = 3'd4,
    RD_REQ  = 3'd5,
    RD_WAIT = 3'd6,
    TX_WAIT = 3'd7
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_SEND = 8'h53;

  state_t            state;
  logic              is_send;
  logic [15:0]       len;
  logic [15:0]       count;
  logic [15:0]       count_inc;
  logic              tx_start_r;
  logic [7:0]        tx_in_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;

  assign count_inc     = count + 16'd1;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;
  assign bus.tx_start  = tx_start_r;
  assign bus.tx_in     = tx_in_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      is_send     <= 1'b0;
      len         <= '0;
      count       <= '0;
      tx_start_r  <= 1'b0;
      tx_in_r     <= 8'h00;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'h00;
      done_tick   <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      mem_we_r   <= 1'b0;
      done_tick  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_done_tick && (bus.rx_out == CMD_LOAD || bus.rx_out == CMD_SEND)) begin
            is_send <= (bus.rx_out == CMD_SEND);
            count   <= '0;
            state   <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (bus.rx_done_tick) begin
            len[15:8] <= bus.rx_out;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (bus.rx_done_tick) begin
            len[7:0] <= bus.rx_out;
            if ({len[15:8], bus.rx_out} == 16'd0) begin
              if (is_send) begin
                done_tick <= 1'b1;
                state     <= IDLE;
              end else begin
                tx_start_r <= 1'b1;
                tx_in_r    <= ACK_BYTE;
                state      <= ACK;
              end
            end else if (is_send) begin
              mem_addr_r <= '0;
              state      <= RD_REQ;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          // Leave only after the last write strobe has been seen, so mem_we never spills into ACK.
          if (count == len) begin
            tx_start_r <= 1'b1;
            tx_in_r    <= ACK_BYTE;
            state      <= ACK;
          end else if (bus.rx_done_tick) begin
            mem_we_r    <= 1'b1;
            mem_wdata_r <= bus.rx_out;
            mem_addr_r  <= count[ADDR_W-1:0];
            count       <= count_inc;
          end
        end
        ACK: begin
          if (bus.tx_done_tick) begin
            done_tick <= 1'b1;
            state     <= IDLE;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          tx_in_r    <= bus.mem_rdata;
          tx_start_r <= 1'b1;
          state      <= TX_WAIT;
        end
        TX_WAIT: begin
          if (bus.tx_done_tick) begin
            count <= count_inc;
            if (count_inc == len) begin
              done_tick <= 1'b1;
              state     <= IDLE;
            end else begin
              mem_addr_r <= count_inc[ADDR_W-1:0];
              state      <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: a wide instance for load/send/reset and a 2-bit-address one for wrap.
module tb_uart_mem_bridge;

  logic clk;
  logic reset;

  uart_mem_bridge_if #(.ADDR_W(16)) a_if ();
  uart_mem_bridge_if #(.ADDR_W(2))  b_if ();

  logic       a_busy, a_done;
  logic [2:0] a_state;
  logic       b_busy, b_done;
  logic [2:0] b_state;

  uart_mem_bridge #(.ADDR_W(16), .ACK_BYTE(8'h41)) u_dut_a (
    .clk(clk), .reset(reset), .bus(a_if),
    .busy(a_busy), .done_tick(a_done), .state_dbg(a_state)
  );

  uart_mem_bridge #(.ADDR_W(2), .ACK_BYTE(8'h41)) u_dut_b (
    .clk(clk), .reset(reset), .bus(b_if),
    .busy(b_busy), .done_tick(b_done), .state_dbg(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory models
  logic [7:0] mem_a [0:65535];
  always @(posedge clk) begin
    if (a_if.mem_we) mem_a[a_if.mem_addr] <= a_if.mem_wdata;
    a_if.mem_rdata <= mem_a[a_if.mem_addr];
  end

  // monitors and UART transmitter responders
  logic [7:0]  tx_q [$];
  logic [23:0] wr_q [$];
  logic [23:0] b_wr_q [$];
  int a_cnt = 0, b_cnt = 0;
  int a_done_cnt = 0, b_done_cnt = 0;
  int overlap = 0, hold_bad = 0, we_bad = 0;
  logic [7:0] a_last_tx = 8'h00;

  always @(negedge clk) begin
    a_if.tx_done_tick = 1'b0;
    if (a_if.tx_start) begin
      if (a_cnt > 0) overlap++;
      tx_q.push_back(a_if.tx_in);
      a_last_tx = a_if.tx_in;
      a_cnt = 4;
    end else if (a_cnt > 0) begin
      a_cnt--;
      if (a_if.tx_in !== a_last_tx) hold_bad++;
      if (a_cnt == 0) a_if.tx_done_tick = 1'b1;
    end
    if (a_if.mem_we) wr_q.push_back({a_if.mem_addr, a_if.mem_wdata});
    if (a_if.mem_we && a_state != 3'd3) we_bad++;
    if (a_done) a_done_cnt++;
  end

  always @(negedge clk) begin
    b_if.tx_done_tick = 1'b0;
    if (b_if.tx_start) b_cnt = 3;
    else if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) b_if.tx_done_tick = 1'b1;
    end
    if (b_if.mem_we) b_wr_q.push_back({14'd0, b_if.mem_addr, b_if.mem_wdata});
    if (b_if.mem_we && b_state != 3'd3) we_bad++;
    if (b_done) b_done_cnt++;
  end

  // driver tasks
  task automatic rx_byte(input int inst, input logic [7:0] b);
    @(negedge clk);
    if (inst == 0) begin a_if.rx_out = b; a_if.rx_done_tick = 1'b1; end
    else           begin b_if.rx_out = b; b_if.rx_done_tick = 1'b1; end
    @(negedge clk);
    a_if.rx_done_tick = 1'b0;
    b_if.rx_done_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int inst, input int prev, input string tag);
    int n = 0;
    while (((inst == 0) ? a_done_cnt : b_done_cnt) == prev && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, ((inst == 0) ? a_done_cnt : b_done_cnt) - prev, 1);
    repeat (2) @(negedge clk);
  endtask

  // scoreboard
  logic [7:0]  exp_q [$];
  logic [23:0] exp_wr_q [$];

  task automatic check_tx(input string tag);
    check({tag, "_tx_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'hDEAD_BEEF, {24'd0, exp_q[i]});
  endtask

  task automatic check_wr(input string tag, input int inst);
    int sz;
    sz = (inst == 0) ? wr_q.size() : b_wr_q.size();
    check({tag, "_wr_len"}, sz, exp_wr_q.size());
    for (int i = 0; i < exp_wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i),
            (i < sz) ? {8'd0, ((inst == 0) ? wr_q[i] : b_wr_q[i])} : 32'hDEAD_BEEF,
            {8'd0, exp_wr_q[i]});
  endtask

  task automatic clear_logs();
    tx_q.delete();
    wr_q.delete();
    b_wr_q.delete();
    exp_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"},  a_if.tx_start, 0);
    check({tag, "_tx_in"},     a_if.tx_in, 0);
    check({tag, "_mem_we"},    a_if.mem_we, 0);
    check({tag, "_mem_addr"},  a_if.mem_addr, 0);
    check({tag, "_mem_wdata"}, a_if.mem_wdata, 0);
    check({tag, "_busy"},      a_busy, 0);
    check({tag, "_done"},      a_done, 0);
    check({tag, "_state"},     a_state, 0);
  endtask

  initial begin
    int prev;
    reset = 1'b0;
    a_if.rx_done_tick = 1'b0; a_if.rx_out = 8'h00; a_if.tx_done_tick = 1'b0;
    b_if.rx_done_tick = 1'b0; b_if.rx_out = 8'h00; b_if.tx_done_tick = 1'b0;
    b_if.mem_rdata = 8'h00;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // load 3 bytes
    clear_logs();
    prev = a_done_cnt;
    rx_byte(0, 8'h4C); rx_byte(0, 8'h00); rx_byte(0, 8'h03);
    rx_byte(0, 8'hAA); rx_byte(0, 8'hBB); rx_byte(0, 8'hCC);
    wait_done(0, prev, "load_done");
    exp_wr_q = '{24'h0000AA, 24'h0001BB, 24'h0002CC};
    exp_q    = '{8'h41};
    check_wr("load", 0);
    check_tx("load");
    check("load_idle", a_busy, 0);

    // send 3 bytes, with a stray command byte injected while waiting on the transmitter
    clear_logs();
    prev = a_done_cnt;
    rx_byte(0, 8'h53); rx_byte(0, 8'h00); rx_byte(0, 8'h03);
    begin
      int n = 0;
      while (tx_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    end
    rx_byte(0, 8'h4C);
    wait_done(0, prev, "send_done");
    exp_q = '{8'hAA, 8'hBB, 8'hCC};
    check_tx("send");
    check_wr("send", 0);
    check("send_idle", a_busy, 0);

    // zero-length load and send
    clear_logs();
    prev = a_done_cnt;
    rx_byte(0, 8'h4C); rx_byte(0, 8'h00); rx_byte(0, 8'h00);
    wait_done(0, prev, "zload_done");
    exp_q = '{8'h41};
    check_tx("zload");
    check_wr("zload", 0);
    clear_logs();
    prev = a_done_cnt;
    rx_byte(0, 8'h53); rx_byte(0, 8'h00); rx_byte(0, 8'h00);
    wait_done(0, prev, "zsend_done");
    check_tx("zsend");

    // garbage in IDLE
    rx_byte(0, 8'h7F);
    check("garbage_busy", a_busy, 0);
    check("garbage_state", a_state, 0);

    // address wrap on the 2-bit instance
    clear_logs();
    prev = b_done_cnt;
    rx_byte(1, 8'h4C); rx_byte(1, 8'h00); rx_byte(1, 8'h05);
    for (int i = 1; i <= 5; i++) rx_byte(1, 8'(i));
    wait_done(1, prev, "wrap_done");
    exp_wr_q = '{24'h000001, 24'h000102, 24'h000203, 24'h000304, 24'h000005};
    check_wr("wrap", 1);

    // reset after the second data byte of a 4-byte load
    clear_logs();
    rx_byte(0, 8'h4C); rx_byte(0, 8'h00); rx_byte(0, 8'h04);
    rx_byte(0, 8'h11); rx_byte(0, 8'h22);
    check("midload_busy", a_busy, 1);
    #3 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_busy", a_busy, 0);
    clear_logs();
    prev = a_done_cnt;
    rx_byte(0, 8'h53); rx_byte(0, 8'h00); rx_byte(0, 8'h01);
    wait_done(0, prev, "postrst_done");
    exp_q = '{8'h11};
    check_tx("postrst");
    check_wr("postrst", 0);

    check("tx_overlap", overlap, 0);
    check("tx_hold", hold_bad, 0);
    check("we_outside_load", we_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 Parameter: ADDR_W, default 16, memory address width (1..16).
REQ-002 Parameter: ACK_BYTE, default 8'h41, byte transmitted after a completed load.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: rx_done_tick  input  1  one-cycle pulse; received byte valid on rx_out.
REQ-006 Port: rx_out  input  8  received byte from the UART receiver.
REQ-007 Port: tx_start  output  1  one-cycle pulse requesting transmission of tx_in.
REQ-008 Port: tx_in  output  8  byte to transmit; held stable from the tx_start pulse until tx_done_tick.
REQ-009 Port: tx_done_tick  input  1  one-cycle pulse; UART transmitter finished the current byte.
REQ-010 Port: mem_addr  output  ADDR_W  memory address.
REQ-011 Port: mem_wdata  output  8  memory write data.
REQ-012 Port: mem_we  output  1  memory write enable, one cycle per byte.
REQ-013 Port: mem_rdata  input  8  memory read data, valid exactly 1 cycle after mem_addr is presented.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done_tick  output  1  one-cycle pulse on completion of a load (after the ACK) or of a send.

Function
REQ-016 Command protocol: 1 command byte, then length high byte, then length low byte (N, 16-bit unsigned).
REQ-017 Command 8'h4C ('L'), load: the next N received bytes are written to addresses 0..N-1; then ACK_BYTE is transmitted.
REQ-018 Command 8'h53 ('S'), send: memory addresses 0..N-1 are read and transmitted in order.
REQ-019 Any other byte in IDLE is discarded; the FSM stays in IDLE.
REQ-020 FSM states: IDLE, LEN_HI, LEN_LO, LOAD, ACK, RD_REQ, RD_WAIT, TX_WAIT.
REQ-021 Transitions: IDLE->LEN_HI on a valid command byte; LEN_HI->LEN_LO on the next byte; LEN_LO->LOAD or RD_REQ on the next byte, per the latched command.
REQ-022 LOAD: on each rx_done_tick, the cycle after assert mem_we=1 with mem_wdata=byte and mem_addr=count[ADDR_W-1:0], then increment count; after byte N go to ACK.
REQ-023 ACK: pulse tx_start with tx_in=ACK_BYTE; on tx_done_tick pulse done_tick and return to IDLE.
REQ-024 RD_REQ: drive mem_addr=count for one cycle -> RD_WAIT.
REQ-025 RD_WAIT: capture mem_rdata into tx_in, pulse tx_start -> TX_WAIT.
REQ-026 TX_WAIT: on tx_done_tick, increment count; if count==N, pulse done_tick -> IDLE, else -> RD_REQ.
REQ-027 N=0, load: go directly from LEN_LO to ACK; no mem_we.
REQ-028 N=0, send: pulse done_tick and return to IDLE; no tx_start.
REQ-029 N>2^ADDR_W: address wraps modulo 2^ADDR_W; the count still runs to N.
REQ-030 rx_done_tick in ACK, RD_REQ, RD_WAIT or TX_WAIT is ignored; the byte is dropped.
REQ-031 tx_done_tick outside ACK/TX_WAIT is ignored.
REQ-032 tx_start never asserts while a previous byte is outstanding; at most one byte is in flight.
REQ-033 mem_we is never high in any state other than LOAD.

Reset
REQ-034 While reset=0 (asynchronously): FSM=IDLE, count=0, N=0; tx_start=0, tx_in=8'h00, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done_tick=0.
REQ-035 Reset asserted mid-operation aborts the transfer; no pending write or tx_start is issued after reset deasserts.
REQ-036 The first rising clk edge after reset deasserts is processed normally in IDLE.

Verification
REQ-037 Load: rx bytes 4C,00,03,AA,BB,CC -> mem_we pulses at addr 0,1,2 with data AA,BB,CC; then tx_start with tx_in=41; done_tick follows tx_done_tick.
REQ-038 Send after load: rx bytes 53,00,03 -> tx_in sequence AA,BB,CC, each with a single tx_start, the next tx_start only after tx_done_tick; done_tick after the third.
REQ-039 Zero length: 4C,00,00 -> ACK 41 sent, no mem_we; 53,00,00 -> done_tick, no tx_start.
REQ-040 Garbage and overlap: rx byte 7F in IDLE -> busy stays 0; rx byte injected during TX_WAIT -> dropped, tx sequence unchanged.
REQ-041 Wrap: ADDR_W=2, load N=5 -> mem_we at addrs 0,1,2,3,0.
REQ-042 Reset after the 2nd data byte of a 4-byte load -> all outputs at reset values; a subsequent 53,00,01 transmits mem[0] correctly.
